// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cartridge RAM arbiter (mem_arb).
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W      = 23;
    localparam int unsigned MEM_ACC_CYC_DEF = 4;
    localparam int unsigned MEM_CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        DONE = 2'd2
    } mem_slot_state_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-2:0] addr;
        logic [15:0]           dati;
        logic                  lbe;
        logic                  ube;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_sync.sv
// Two-flop synchroniser plus rising-edge detector for the CPU request level.
module mem_arb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise_c = sh[1] & ~sh[2];

endmodule

// File: rtl/mem_arb.sv
// Single-port arbiter/sequencer for the 16-bit cartridge RAM (CPU byte path vs DMA word path).
// Define MEM_ARB_FAIR_EN to alternate CPU and DMA grants instead of strict CPU priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned ACC_CYC = MEM_ACC_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dati,
    output logic [7:0]        cpu_dato,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_dati,
    output logic [15:0]       dma_dato,
    output logic              dma_ack,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_dati,
    input  logic [15:0]       mem_dato,
    output logic              mem_ce,
    output logic              mem_oe,
    output logic              mem_we,
    output logic              mem_lbe,
    output logic              mem_ube
);

    localparam logic [MEM_CNT_W-1:0] CNT_LAST = MEM_CNT_W'(ACC_CYC - 1);
    localparam logic [MEM_CNT_W-1:0] CNT_WEND = MEM_CNT_W'(ACC_CYC - 2);

    mem_slot_state_e      state;
    logic [MEM_CNT_W-1:0] cnt;
    logic                 gnt_dma;
    logic                 slot_we;
    logic                 cpu_pend;
    logic                 cpu_we_q;
    logic [ADDR_W-1:0]    cpu_addr_q;
    logic [7:0]           cpu_dati_q;
    logic                 cpu_rise_c;
    logic                 grant_dma_c;
    mem_req_t             cpu_rq_c;
    mem_req_t             dma_rq_c;
    mem_req_t             req_c;
    logic                 unused_dma_lsb;

    assign unused_dma_lsb = dma_addr[0];

    mem_arb_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (cpu_req),
        .rise_c (cpu_rise_c)
    );

`ifdef MEM_ARB_FAIR_EN
    logic dma_turn;

    // After a CPU slot with DMA waiting, the next grant belongs to DMA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_turn <= 1'b0;
        end else if (state == IDLE && grant_dma_c) begin
            dma_turn <= 1'b0;
        end else if (state == DONE && !gnt_dma && dma_req) begin
            dma_turn <= 1'b1;
        end
    end

    assign grant_dma_c = dma_req && (dma_turn || !cpu_pend);
`else
    assign grant_dma_c = dma_req && !cpu_pend;
`endif

    // CPU writes put the byte on both halves; the lane enable picks the target.
    assign cpu_rq_c = '{we:   cpu_we_q,
                        addr: (MEM_ADDR_W-1)'(cpu_addr_q[ADDR_W-1:1]),
                        dati: {cpu_dati_q, cpu_dati_q},
                        lbe:  !cpu_addr_q[0],
                        ube:  cpu_addr_q[0]};

    assign dma_rq_c = '{we:   dma_we,
                        addr: (MEM_ADDR_W-1)'(dma_addr[ADDR_W-1:1]),
                        dati: dma_dati,
                        lbe:  1'b1,
                        ube:  1'b1};

    assign req_c = grant_dma_c ? dma_rq_c : cpu_rq_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt_dma    <= 1'b0;
            slot_we    <= 1'b0;
            cpu_pend   <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_dati_q <= 8'h00;
            cpu_dato   <= 8'hFF;
            cpu_done   <= 1'b0;
            dma_dato   <= 16'hFFFF;
            dma_ack    <= 1'b0;
            mem_addr   <= '0;
            mem_dati   <= 16'h0000;
            mem_ce     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_lbe    <= 1'b0;
            mem_ube    <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            dma_ack  <= 1'b0;

            // Edges arriving while a CPU access is still pending are dropped.
            if (cpu_rise_c && !cpu_pend) begin
                cpu_pend   <= 1'b1;
                cpu_we_q   <= cpu_we;
                cpu_addr_q <= cpu_addr;
                cpu_dati_q <= cpu_dati;
            end

            case (state)
                IDLE: begin
                    if (cpu_pend || dma_req) begin
                        state    <= SLOT;
                        cnt      <= '0;
                        gnt_dma  <= grant_dma_c;
                        slot_we  <= req_c.we;
                        mem_addr <= (ADDR_W-1)'(req_c.addr);
                        mem_dati <= req_c.dati;
                        mem_ce   <= 1'b1;
                        mem_oe   <= !req_c.we;
                        mem_we   <= 1'b0;
                        mem_lbe  <= req_c.lbe;
                        mem_ube  <= req_c.ube;
                    end
                end
                SLOT: begin
                    cnt    <= cnt + MEM_CNT_W'(1);
                    // First cycle is setup, last cycle is hold.
                    mem_we <= slot_we && (cnt < CNT_WEND);
                    if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        mem_ce  <= 1'b0;
                        mem_oe  <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_lbe <= 1'b0;
                        mem_ube <= 1'b0;
                        if (gnt_dma) begin
                            dma_ack <= 1'b1;
                            if (!slot_we) begin
                                dma_dato <= mem_dato;
                            end
                        end else begin
                            cpu_done <= 1'b1;
                            cpu_pend <= 1'b0;
                            if (!slot_we) begin
                                cpu_dato <= cpu_addr_q[0] ? mem_dato[15:8] : mem_dato[7:0];
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
